// File: rtl/aes_cbc_ctrl.sv
// CBC chaining controller between a block stream and the AES core start/done interface.
// One block in flight at a time: accept, start the core, wait for done, present the result.
module aes_cbc_ctrl #(
  parameter int BLK_W = 128,
  parameter int KEY_W = 256,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iv_load,
  input  logic [BLK_W-1:0] iv,
  input  logic [1:0]       mode,
  input  logic [KEY_W-1:0] key,
  input  logic             enc_dec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             core_start,
  output logic             core_enc_dec,
  output logic [1:0]       core_mode,
  output logic [KEY_W-1:0] core_key,
  output logic [BLK_W-1:0] core_data_in,
  input  logic [BLK_W-1:0] core_data_out,
  input  logic             core_done,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [BLK_W-1:0] chain_q, chain_d;
  logic [BLK_W-1:0] hold_q, hold_d;
  logic [BLK_W-1:0] core_data_in_q, core_data_in_d;
  logic             core_enc_dec_q, core_enc_dec_d;
  logic [1:0]       core_mode_q, core_mode_d;
  logic             core_start_q, core_start_d;
  logic [BLK_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] blk_count_q, blk_count_d;
  logic [BLK_W-1:0] chain_eff;
  logic             accept;

  // Both streams: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready depends only on state/reset.
  assign in_ready     = (state_q == S_IDLE) & ~reset;
  assign accept       = in_valid & in_ready;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign core_start   = core_start_q;
  assign core_enc_dec = core_enc_dec_q;
  assign core_mode    = core_mode_q;
  assign core_key     = key;
  assign core_data_in = core_data_in_q;
  assign busy         = (state_q != S_IDLE);
  assign blk_count    = blk_count_q;
  assign dbg_state    = state_q;

  always_comb begin
    state_d        = state_q;
    chain_d        = chain_q;
    hold_d         = hold_q;
    core_data_in_d = core_data_in_q;
    core_enc_dec_d = core_enc_dec_q;
    core_mode_d    = core_mode_q;
    core_start_d   = 1'b0;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    blk_count_d    = blk_count_q;
    chain_eff      = iv_load ? iv : chain_q;

    case (state_q)
      S_IDLE: begin
        if (iv_load) begin
          chain_d     = iv;
          blk_count_d = '0;
        end
        if (accept) begin
          core_enc_dec_d = enc_dec;
          core_mode_d    = mode;
          // Decipher keeps the raw ciphertext: it becomes the chain once the block completes.
          if (!enc_dec) begin
            core_data_in_d = in_data ^ chain_eff;
          end else begin
            core_data_in_d = in_data;
            hold_d         = in_data;
          end
          core_start_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          if (!core_enc_dec_q) begin
            out_data_d = core_data_out;
            chain_d    = core_data_out;
          end else begin
            out_data_d = core_data_out ^ chain_q;
            chain_d    = hold_q;
          end
          out_valid_d = 1'b1;
          blk_count_d = blk_count_q + CNT_W'(1);
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      chain_q        <= '0;
      hold_q         <= '0;
      core_data_in_q <= '0;
      core_enc_dec_q <= 1'b0;
      core_mode_q    <= 2'b00;
      core_start_q   <= 1'b0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      blk_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      chain_q        <= chain_d;
      hold_q         <= hold_d;
      core_data_in_q <= core_data_in_d;
      core_enc_dec_q <= core_enc_dec_d;
      core_mode_q    <= core_mode_d;
      core_start_q   <= core_start_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      blk_count_q    <= blk_count_d;
    end
  end

endmodule
